// File: rtl/pattern_match_ctrl_if.sv
// Host-side bundle for the pattern match run controller: configuration
// handshake, run control, serial stream and result signals.
interface pattern_match_ctrl_if #(
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 8
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [PAT_MAX-1:0] cfg_pattern;
    logic [3:0]         cfg_len;
    logic [CNT_W-1:0]   cfg_target;
    logic               cfg_err;
    logic               start;
    logic               abort;
    logic               in;
    logic               in_valid;
    logic               busy;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               done;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_target,
        output start, abort, in, in_valid,
        input  cfg_ready, cfg_err, busy, match, match_count, done
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_target,
        input  start, abort, in, in_valid,
        output cfg_ready, cfg_err, busy, match, match_count, done
    );
endinterface

// File: rtl/pattern_match_ctrl.sv
// Run controller for a programmable serial pattern detector: latches a
// pattern/target, scans the qualified bit stream and counts overlapping matches.
module pattern_match_ctrl #(
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    pattern_match_ctrl_if.slave  bus
);
    localparam int FILL_W = $clog2(PAT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [PAT_MAX-1:0] pat_q, pat_d;
    logic [3:0]         len_q, len_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [PAT_MAX-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               match_q, match_d;
    logic               cfg_err_q, cfg_err_d;

    logic [PAT_MAX-1:0] len_mask;
    logic [PAT_MAX-1:0] hist_new;
    logic [FILL_W-1:0]  fill_new;
    logic [CNT_W-1:0]   count_inc;
    logic               hit;
    logic               cfg_fire;
    logic               cfg_legal;

    // Only the low len_q bits of history and pattern take part in the compare.
    generate
        for (genvar gi = 0; gi < PAT_MAX; gi++) begin : g_mask
            assign len_mask[gi] = (int'(len_q) > gi);
        end
    endgenerate

    assign hist_new  = PAT_MAX'({hist_q, bus.in});
    assign fill_new  = (fill_q == FILL_W'(PAT_MAX)) ? fill_q : fill_q + FILL_W'(1);
    assign hit       = (((hist_new ^ pat_q) & len_mask) == '0) &&
                       (int'(fill_new) >= int'(len_q));
    assign count_inc = count_q + CNT_W'(1);

    assign cfg_fire  = bus.cfg_valid && (state_q != S_RUN);
    assign cfg_legal = (bus.cfg_len != 4'd0) && (int'(bus.cfg_len) <= PAT_MAX) &&
                       (bus.cfg_target != '0);

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        target_d  = target_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        count_d   = count_q;
        match_d   = 1'b0;
        cfg_err_d = 1'b0;

        // A configuration offer takes priority over start in ARMED/DONE.
        if (cfg_fire) begin
            if (cfg_legal) begin
                pat_d    = bus.cfg_pattern;
                len_d    = bus.cfg_len;
                target_d = bus.cfg_target;
                count_d  = '0;
                state_d  = S_ARMED;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_ARMED, S_DONE: begin
                    if (bus.start) begin
                        hist_d  = '0;
                        fill_d  = '0;
                        count_d = '0;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        state_d = S_ARMED;
                    end else if (bus.in_valid) begin
                        hist_d = hist_new;
                        fill_d = fill_new;
                        if (hit) begin
                            match_d = 1'b1;
                            count_d = count_inc;
                            if (count_inc == target_q) begin
                                state_d = S_DONE;
                            end
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            target_q  <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            count_q   <= '0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            target_q  <= target_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            count_q   <= count_d;
            match_q   <= match_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign bus.cfg_ready   = (state_q != S_RUN);
    assign bus.busy        = (state_q == S_RUN);
    assign bus.done        = (state_q == S_DONE);
    assign bus.match       = match_q;
    assign bus.match_count = count_q;
    assign bus.cfg_err     = cfg_err_q;
endmodule

// File: doc/pattern_match_ctrl.md
# pattern_match_ctrl

Run controller for a programmable serial pattern detector. It accepts a pattern and a match target through a valid/ready configuration handshake. On start it scans a qualified serial bit stream for the pattern, with overlapping matches allowed, and counts matches until the target is reached or the run is aborted. It sits between the host/config logic and the serial input path, and replaces fixed-pattern detectors wherever the pattern must change at run time.

## Interface
- PAT_MAX, 8, maximum pattern length in bits; sets the width of `cfg_pattern` and of the history register.
- CNT_W, 8, width of the match counter and of the match target.

Ports:
- clock  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high; applied at posedge clock.
- cfg_valid  in  1  a configuration word is presented.
- cfg_ready  out  1  a configuration can be accepted; high in every state except RUN.
- cfg_pattern  in  PAT_MAX  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  4  pattern length, legal range 1..PAT_MAX.
- cfg_target  in  CNT_W  number of matches that ends a run, legal range 1..2^CNT_W-1.
- cfg_err  out  1  one-cycle pulse: an illegal configuration was offered and rejected.
- start  in  1  begin a run.
- abort  in  1  end a run early.
- in  in  1  serial data bit.
- in_valid  in  1  qualifies `in`; bits are sampled only when this is high in RUN.
- busy  out  1  high while in RUN.
- match  out  1  one-cycle pulse per detected match.
- match_count  out  CNT_W  matches counted in the current or most recent run.
- done  out  1  level; high while in DONE.

## Operation
States:
- IDLE: no valid configuration held.
- ARMED: configuration held, waiting for `start`.
- RUN: scanning the stream.
- DONE: target reached.

Configuration:
- A handshake completes on any posedge where `cfg_valid` and `cfg_ready` are both high.
- Legal word: latch pattern, length and target, go to ARMED, clear `match_count`.
- Illegal word (`cfg_len` = 0, `cfg_len` > PAT_MAX, or `cfg_target` = 0): pulse `cfg_err` for one cycle. State and the held configuration are unchanged.

Transitions:
- ARMED or DONE with `start` = 1: go to RUN. Clear history, fill counter and `match_count`.
- `start` in IDLE or in RUN is ignored.
- RUN with `abort` = 1: go to ARMED. The configuration and `match_count` are retained for readback.

Detection in RUN, on each sampled bit:
- history <= {history[PAT_MAX-2:0], in}.
- The fill counter increments and saturates at PAT_MAX.
- A match occurs when the new history[len-1:0] equals pattern[len-1:0] and the new fill is at least len.
- A match leaves history and fill untouched, so matches may overlap.
- Each match pulses `match` and increments `match_count`. If the new count equals the target, go to DONE.

Precedence and boundary rules:
- `abort` and a sampled bit in the same cycle: abort wins and the bit is discarded, with no match and no count.
- `reset` overrides everything, including mid-run.
- `match_count` never wraps, because a run stops at the target.
- In DONE and ARMED the stream is ignored.
- DONE plus `cfg_valid` accepts the new configuration, with the same legality check as above.

Reset values:
- State IDLE, `cfg_ready` = 1.
- `cfg_err`, `busy`, `match` and `done` = 0.
- `match_count` = 0; history, fill and the held configuration cleared.

## Timing
- All outputs are registered.
- `match` and the new `match_count` appear immediately after the posedge that samples the completing bit. Latency is 0 cycles after the sampling edge, with no extra pipeline stage.
- `done` rises and `busy` falls after the same edge as the final `match`.
- `cfg_err` rises after the offending edge and falls after the next edge.
- `busy` rises after the `start` edge. The first bit can be sampled on the following edge.
- `cfg_ready` is low from the `start` edge until the edge that leaves RUN.
- `in_valid` low: history, fill and count hold; no match.
- Back-to-back valid bits: one bit per clock, no bubbles.

## Test plan
- **Reset:** drive `reset` for 2 cycles, then check every output against its reset value. Mid-run `reset` returns to IDLE next cycle with `match_count` = 0.
- **Overlapping match:** config pattern 10001, len 5, target 3. Start, then stream 1,0,0,0,1,0,0,0,1. Expect `match` after bit 5 and bit 9, `match_count` 1 then 2, still in RUN.
- **Done:** continue the previous scenario with 0,0,0,1. Expect the third `match`, `match_count` = 3, `done` = 1, `busy` = 0. Further bits leave the count at 3.
- **Illegal config:** offer `cfg_len` = 0, then `cfg_len` = 9, then `cfg_target` = 0. Expect one `cfg_err` pulse each and no state change. In RUN, `cfg_valid` sees `cfg_ready` = 0 and is not accepted.
- **Abort priority:** pattern 11, len 2, target 5. Stream 1 then 1, with `abort` on the second bit. Expect no match, state ARMED, `match_count` = 0. Restart with `start`, stream 1,1,1 and expect 2 matches.
- **Gaps:** pattern 101, len 3. Stream 1, gap with `in_valid` low for 3 cycles, 0, 1. Expect exactly one match on the final bit.
